// File: rtl/bank_prog_ctrl.sv
// Programming sequencer for a tile-row configuration fabric: loads one frame per row onto the
// bitline bus, then strobes that row's wordline after a setup window.
module bank_prog_ctrl #(
  parameter int BL_WIDTH  = 40,
  parameter int WL_WIDTH  = 4,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2
) (
  input  logic                prog_clk,
  input  logic                prog_rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [BL_WIDTH-1:0] cfg_data,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic [BL_WIDTH-1:0] bl,
  output logic [WL_WIDTH-1:0] wl,
  output logic                busy,
  output logic                done,
  output logic                aborted
);

  localparam int ROW_W  = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1;
  localparam int PH_MAX = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(WL_WIDTH - 1);
  localparam logic [PH_W-1:0]  SETUP_LAST = PH_W'(SETUP_CYC - 1);
  localparam logic [PH_W-1:0]  PULSE_LAST = PH_W'(PULSE_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    PULSE,
    HOLD
  } state_e;

  state_e              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [BL_WIDTH-1:0] bl_q, bl_d;
  logic [WL_WIDTH-1:0] wl_q, wl_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic                handshake;
  logic                abort_run;

  assign handshake = (state_q == LOAD) && cfg_valid && cfg_ready_q;
  assign abort_run = abort && (state_q != IDLE);

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      phase_q     <= '0;
      bl_q        <= '0;
      wl_q        <= '0;
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      phase_q     <= phase_d;
      bl_q        <= bl_d;
      wl_q        <= wl_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  // Abort wins over every other transition, including a LOAD handshake in the same cycle.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    phase_d = phase_q;
    if (abort_run) begin
      state_d = IDLE;
      row_d   = '0;
      phase_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = LOAD;
            row_d   = '0;
          end
        end
        LOAD: begin
          if (handshake) begin
            state_d = SETUP;
            phase_d = '0;
          end
        end
        SETUP: begin
          if (phase_q == SETUP_LAST) begin
            state_d = PULSE;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        PULSE: begin
          if (phase_q == PULSE_LAST) begin
            state_d = HOLD;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        HOLD: begin
          if (row_q == LAST_ROW) begin
            state_d = IDLE;
            row_d   = '0;
          end else begin
            state_d = LOAD;
            row_d   = row_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          row_d   = '0;
          phase_d = '0;
        end
      endcase
    end
  end

  // Registered outputs are derived from the upcoming state so they line up with it exactly.
  always_comb begin
    wl_d        = '0;
    cfg_ready_d = (state_d == LOAD);
    busy_d      = (state_d != IDLE);
    aborted_d   = abort_run;
    done_d      = !abort_run && (state_q == HOLD) && (row_q == LAST_ROW);
    bl_d        = bl_q;
    if (handshake && !abort_run) begin
      bl_d = cfg_data;
    end
    if (state_d == PULSE) begin
      wl_d = WL_WIDTH'(1) << row_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign bl        = bl_q;
  assign wl        = wl_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_bank_prog_ctrl.sv
// Directed bench for bank_prog_ctrl: full runs, stalled load, aborts, ignored start/abort,
// and reset mid-run, with a background wordline/bitline integrity checker.
module tb_bank_prog_ctrl;

  localparam int BLW = 40;
  localparam int WLW = 4;

  logic           prog_clk   = 1'b0;
  logic           prog_rst_n = 1'b0;
  logic           start      = 1'b0;
  logic           abort      = 1'b0;
  logic           cfg_valid  = 1'b0;
  logic [BLW-1:0] cfg_data   = '0;
  logic           cfg_ready;
  logic [BLW-1:0] bl;
  logic [WLW-1:0] wl;
  logic           busy;
  logic           done;
  logic           aborted;

  int checks    = 0;
  int errors    = 0;
  int busy_cnt  = 0;
  int abort_cnt = 0;

  logic [BLW-1:0] frames [4];
  logic [BLW-1:0] prev_bl = '0;
  logic [WLW-1:0] prev_wl = '0;

  bank_prog_ctrl #(
    .BL_WIDTH (BLW),
    .WL_WIDTH (WLW),
    .SETUP_CYC(1),
    .PULSE_CYC(2)
  ) dut (
    .prog_clk  (prog_clk),
    .prog_rst_n(prog_rst_n),
    .start     (start),
    .abort     (abort),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .bl        (bl),
    .wl        (wl),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic v, input logic [BLW-1:0] d);
    start     = s;
    abort     = a;
    cfg_valid = v;
    cfg_data  = d;
  endtask

  task automatic step();
    @(posedge prog_clk);
    #1;
  endtask

  // Wordlines must be one-hot or zero, and bitlines frozen while a wordline is up.
  always @(negedge prog_clk) begin
    if (busy) busy_cnt++;
    if (aborted) abort_cnt++;
    checkOutput("wl_onehot0", {63'd0, $onehot0(wl)}, 64'd1);
    if (wl != '0 && prev_wl != '0) checkOutput("bl_stable", {24'd0, bl}, {24'd0, prev_bl});
    prev_bl = bl;
    prev_wl = wl;
  end

  task automatic startRun(input logic with_abort);
    applyStimulus(1'b1, with_abort, 1'b0, cfg_data);
    step();
    checkOutput("start_busy", {63'd0, busy}, 64'd1);
    checkOutput("start_ready", {63'd0, cfg_ready}, 64'd1);
    checkOutput("start_wl", {60'd0, wl}, 64'd0);
    checkOutput("start_aborted", {63'd0, aborted}, 64'd0);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic doRow(input int r, input int stall, input logic [BLW-1:0] prev_frame);
    logic [WLW-1:0] exp_wl;
    exp_wl = WLW'(1) << r;
    applyStimulus(start, 1'b0, (stall == 0), frames[r]);
    repeat (stall) begin
      step();
      checkOutput("stall_ready", {63'd0, cfg_ready}, 64'd1);
      checkOutput("stall_wl", {60'd0, wl}, 64'd0);
      checkOutput("stall_bl", {24'd0, bl}, {24'd0, prev_frame});
    end
    cfg_valid = 1'b1;
    step();
    checkOutput("setup_bl", {24'd0, bl}, {24'd0, frames[r]});
    checkOutput("setup_ready", {63'd0, cfg_ready}, 64'd0);
    checkOutput("setup_wl", {60'd0, wl}, 64'd0);
    checkOutput("setup_busy", {63'd0, busy}, 64'd1);
    repeat (2) begin
      step();
      checkOutput("pulse_wl", {60'd0, wl}, {60'd0, exp_wl});
    end
    step();
    checkOutput("hold_wl", {60'd0, wl}, 64'd0);
    checkOutput("hold_bl", {24'd0, bl}, {24'd0, frames[r]});
    step();
    if (r == WLW - 1) begin
      checkOutput("end_done", {63'd0, done}, 64'd1);
      checkOutput("end_busy", {63'd0, busy}, 64'd0);
      checkOutput("end_ready", {63'd0, cfg_ready}, 64'd0);
      step();
      checkOutput("done_pulse_len", {63'd0, done}, 64'd0);
    end else begin
      checkOutput("next_ready", {63'd0, cfg_ready}, 64'd1);
      checkOutput("next_done", {63'd0, done}, 64'd0);
      checkOutput("next_busy", {63'd0, busy}, 64'd1);
    end
  endtask

  initial begin
    frames[0] = 40'hA0_1234_5670;
    frames[1] = 40'hA1_89AB_CDE1;
    frames[2] = 40'hA2_0F0F_0F02;
    frames[3] = 40'hA3_F00D_BEE3;

    // Reset state
    repeat (2) step();
    checkOutput("rst_bl", {24'd0, bl}, 64'd0);
    checkOutput("rst_wl", {60'd0, wl}, 64'd0);
    checkOutput("rst_ready", {63'd0, cfg_ready}, 64'd0);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_aborted", {63'd0, aborted}, 64'd0);
    prog_rst_n = 1'b1;
    step();

    $display("[TB] test 1: full run");
    busy_cnt = 0;
    startRun(1'b0);
    for (int r = 0; r < 4; r++) doRow(r, 0, '0);
    checkOutput("t1_busy_cycles", 64'(busy_cnt), 64'd20);

    $display("[TB] test 2: stalled load in row 2");
    busy_cnt = 0;
    startRun(1'b0);
    for (int r = 0; r < 4; r++) doRow(r, (r == 2) ? 7 : 0, (r == 0) ? frames[3] : frames[r-1]);
    checkOutput("t2_busy_cycles", 64'(busy_cnt), 64'd27);

    $display("[TB] test 3: abort during pulse of row 1");
    startRun(1'b0);
    doRow(0, 0, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, frames[1]);
    step();
    checkOutput("t3_setup_bl", {24'd0, bl}, {24'd0, frames[1]});
    step();
    checkOutput("t3_pulse_wl", {60'd0, wl}, 64'h2);
    abort = 1'b1;
    step();
    checkOutput("t3_abort_wl", {60'd0, wl}, 64'd0);
    checkOutput("t3_aborted", {63'd0, aborted}, 64'd1);
    checkOutput("t3_abort_busy", {63'd0, busy}, 64'd0);
    checkOutput("t3_abort_ready", {63'd0, cfg_ready}, 64'd0);
    checkOutput("t3_abort_bl", {24'd0, bl}, {24'd0, frames[1]});
    applyStimulus(1'b0, 1'b0, 1'b0, frames[1]);
    step();
    checkOutput("t3_aborted_len", {63'd0, aborted}, 64'd0);
    checkOutput("t3_idle_busy", {63'd0, busy}, 64'd0);
    startRun(1'b0);
    for (int r = 0; r < 4; r++) doRow(r, 0, '0);

    $display("[TB] test 4: abort with load handshake");
    startRun(1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, frames[0]);
    step();
    checkOutput("t4_aborted", {63'd0, aborted}, 64'd1);
    checkOutput("t4_bl_kept", {24'd0, bl}, {24'd0, frames[3]});
    checkOutput("t4_ready", {63'd0, cfg_ready}, 64'd0);
    checkOutput("t4_busy", {63'd0, busy}, 64'd0);
    abort = 1'b0;
    repeat (4) begin
      step();
      checkOutput("t4_no_wl", {60'd0, wl}, 64'd0);
      checkOutput("t4_bl_idle", {24'd0, bl}, {24'd0, frames[3]});
    end
    cfg_valid = 1'b0;

    $display("[TB] test 5: ignored start and abort");
    abort_cnt = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, frames[0]);
    step();
    checkOutput("t5_idle_abort", {63'd0, aborted}, 64'd0);
    checkOutput("t5_idle_busy", {63'd0, busy}, 64'd0);
    busy_cnt = 0;
    startRun(1'b1);
    doRow(0, 0, '0);
    start = 1'b1;
    doRow(1, 0, '0);
    start = 1'b0;
    doRow(2, 0, '0);
    doRow(3, 0, '0);
    checkOutput("t5_busy_cycles", 64'(busy_cnt), 64'd20);
    checkOutput("t5_no_aborted", 64'(abort_cnt), 64'd0);

    $display("[TB] test 6: reset during setup of row 3");
    startRun(1'b0);
    for (int r = 0; r < 3; r++) doRow(r, 0, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, frames[3]);
    step();
    checkOutput("t6_setup_bl", {24'd0, bl}, {24'd0, frames[3]});
    prog_rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_wl", {60'd0, wl}, 64'd0);
    checkOutput("t6_rst_bl", {24'd0, bl}, 64'd0);
    checkOutput("t6_rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("t6_rst_ready", {63'd0, cfg_ready}, 64'd0);
    cfg_valid = 1'b0;
    repeat (2) begin
      step();
      checkOutput("t6_rst_done", {63'd0, done}, 64'd0);
    end
    prog_rst_n = 1'b1;
    repeat (3) begin
      step();
      checkOutput("t6_post_done", {63'd0, done}, 64'd0);
      checkOutput("t6_post_busy", {63'd0, busy}, 64'd0);
      checkOutput("t6_post_wl", {60'd0, wl}, 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
